board_input_ctrl: RTL
=====================

Name: board_input_ctrl

Overview:
Player-side input engine for the Battleship board. It takes raw push-button and switch inputs, synchronises and debounces them, and moves the cursor (cursor_i, cursor_j). It also runs the ship-placement phase and maintains the occupancy bitmap. Its cursor and occupancy outputs drive the vga renderer, the 7-segment decoders and the game FSM.

Parameters:
BOARD_DIM, 5, board rows and columns; legal range 2..8.
MAX_SHIPS, 5, upper clamp on requested ship count; legal range 1..7.
DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a button level is accepted; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  raw button, active-high
move_up, move_down, move_left, move_right  in  1 each  raw buttons, active-high
player_place_ship  in  1  raw button, active-high
amount_of_ships  in  3  requested ship count (switches)
cursor_i  out  3  cursor row
cursor_j  out  3  cursor column
occupied  out  BOARD_DIM*BOARD_DIM  placed-ship bitmap; bit index = i*BOARD_DIM+j
ships_placed  out  3  ships placed so far
target_ships  out  3  latched clamped ship target
placing_active  out  1  high in PLACE state
placing_done  out  1  high in DONE state
place_reject  out  1  one-cycle pulse when a placement is refused

Behaviour:
- Reset (rst=0, async): cursor 0,0; occupied all 0; ships_placed 0; target_ships 0; FSM in IDLE; all pulses 0; debouncers cleared to "released".
- Input path for each button:
  - 2-flop synchroniser.
  - Debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the counter.
  - A rising edge of the debounced level produces a 1-cycle pulse.
  - Holding a button gives exactly one pulse; there is no auto-repeat.
- Latency: raw level stable at cycle 0 → pulse at cycle DEBOUNCE_CYCLES+2 → cursor/bitmap registered update on the next edge.
- FSM IDLE:
  - Cursor movement is ignored.
  - On a start pulse, latch target_ships = min(amount_of_ships, MAX_SHIPS).
  - If the latched target is 0 → DONE, else → PLACE.
- FSM PLACE:
  - At most one action per cycle. Priority: place > up > down > left > right; lower-priority pulses in the same cycle are dropped.
  - up: i-1, saturating at 0. down: i+1, saturating at BOARD_DIM-1. left: j-1, saturating at 0. right: j+1, saturating at BOARD_DIM-1.
  - Place on an empty cell: set the bit and increment ships_placed. If the new count equals target_ships → DONE in the same edge.
  - Place on an occupied cell: no state change; place_reject pulses for 1 cycle.
  - Start pulses are ignored in PLACE.
- FSM DONE:
  - Cursor, bitmap and counts are frozen; all inputs are ignored.
  - Only reset leaves DONE.
- amount_of_ships changes after the start pulse have no effect.
- Reset asserted mid-placement clears everything immediately, with no partial state retained.
- ships_placed never exceeds target_ships; the width is sufficient since MAX_SHIPS ≤ 7.

Optional Feature:
Macro BATTLESHIP_CURSOR_WRAP_EN.
- Defined: cursor wraps at the edges. up at i=0 → BOARD_DIM-1; down at BOARD_DIM-1 → 0; same for j.
- Undefined: saturating movement as above.
- Priority, latency and the FSM are identical in both builds.

Decomposition:
- Package battleship_pkg holds BOARD_DIM and MAX_SHIPS defaults, the coordinate typedef (logic [2:0]), the FSM state enum {IDLE, PLACE, DONE}, and a cell-index helper function (i*BOARD_DIM+j).
- One sub-module, button_debounce: synchroniser, debounce counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES. It is instantiated 6 times.
- The FSM, cursor and bitmap logic live in board_input_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and BOARD_DIM=5.
1. Reset, then press start with amount_of_ships=3 → target_ships=3, placing_active=1; move_right held 20 cycles → exactly one pulse, cursor_j=1 after DEBOUNCE_CYCLES+3 cycles.
2. Bounce move_down (toggle every 2 cycles for 12 cycles, then stable high) → cursor_i changes once, only after 4 stable cycles. Press up 3 times from i=0 → cursor_i stays 0 (without the macro) or reads 4, 3, 2 (with the macro).
3. Place at (0,0), then again at (0,0) → occupied[0]=1, ships_placed=1, place_reject pulses once; move to (2,3), place → occupied[13]=1, ships_placed=2.
4. amount_of_ships=7 → target_ships=5; place 5 distinct cells → placing_done=1; further moves and places leave cursor, occupied and ships_placed unchanged.
5. amount_of_ships=0, start → DONE directly, ships_placed=0, occupied=0.
6. Place and move_left pulses in the same cycle → only the placement happens, cursor unchanged. Assert rst=0 mid-PLACE → all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types and defaults for the Battleship player-input slice.
package battleship_pkg;

  localparam int DEFAULT_BOARD_DIM = 5;
  localparam int DEFAULT_MAX_SHIPS = 5;

  localparam int NUM_BUTTONS = 6;
  localparam int BTN_START   = 0;
  localparam int BTN_UP      = 1;
  localparam int BTN_DOWN    = 2;
  localparam int BTN_LEFT    = 3;
  localparam int BTN_RIGHT   = 4;
  localparam int BTN_PLACE   = 5;

  typedef logic [2:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    PLACE,
    DONE
  } state_e;

  // Flat bitmap index of cell (i, j); boards are at most 8x8 so 6 bits suffice.
  function automatic logic [5:0] cell_idx(input coord_t i, input coord_t j, input int dim);
    return 6'(int'(i) * dim + int'(j));
  endfunction

endpackage

// File: rtl/board_input_ctrl_if.sv
// Button/switch inputs and board-state outputs of board_input_ctrl.
interface board_input_ctrl_if
  import battleship_pkg::*;
#(
  parameter int BOARD_DIM = DEFAULT_BOARD_DIM
);

  logic                           start;
  logic                           move_up;
  logic                           move_down;
  logic                           move_left;
  logic                           move_right;
  logic                           player_place_ship;
  logic [2:0]                     amount_of_ships;

  coord_t                         cursor_i;
  coord_t                         cursor_j;
  logic [BOARD_DIM*BOARD_DIM-1:0] occupied;
  logic [2:0]                     ships_placed;
  logic [2:0]                     target_ships;
  logic                           placing_active;
  logic                           placing_done;
  logic                           place_reject;

  modport master (
    output start, move_up, move_down, move_left, move_right,
           player_place_ship, amount_of_ships,
    input  cursor_i, cursor_j, occupied, ships_placed, target_ships,
           placing_active, placing_done, place_reject
  );

  modport slave (
    input  start, move_up, move_down, move_left, move_right,
           player_place_ship, amount_of_ships,
    output cursor_i, cursor_j, occupied, ships_placed, target_ships,
           placing_active, placing_done, place_reject
  );

endinterface

// File: rtl/board_input_ctrl_debounce.sv
// button_debounce: 2-flop synchroniser, stability counter and rising-edge pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only runs while the synchronised input disagrees; agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign pulse = level_q & ~prev_q;

endmodule

// File: rtl/board_input_ctrl.sv
// Player input engine: debounced buttons, cursor movement and ship placement.
// Define BATTLESHIP_CURSOR_WRAP_EN to make the cursor wrap at board edges.
module board_input_ctrl
  import battleship_pkg::*;
#(
  parameter int BOARD_DIM       = DEFAULT_BOARD_DIM,
  parameter int MAX_SHIPS       = DEFAULT_MAX_SHIPS,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  board_input_ctrl_if.slave bus
);

  localparam int             CELLS = BOARD_DIM * BOARD_DIM;
  localparam coord_t         LAST  = coord_t'(BOARD_DIM - 1);
  localparam logic [2:0]     MAX_T = 3'(MAX_SHIPS);

  logic [NUM_BUTTONS-1:0] raw_btn;
  logic [NUM_BUTTONS-1:0] btn_pulse;

  state_e             state_q, state_d;
  coord_t             ci_q, ci_d;
  coord_t             cj_q, cj_d;
  logic [CELLS-1:0]   occ_q, occ_d;
  logic [2:0]         placed_q, placed_d;
  logic [2:0]         target_q, target_d;
  logic               reject_q, reject_d;
  logic [CELLS-1:0]   cell_mask;

  assign raw_btn[BTN_START] = bus.start;
  assign raw_btn[BTN_UP]    = bus.move_up;
  assign raw_btn[BTN_DOWN]  = bus.move_down;
  assign raw_btn[BTN_LEFT]  = bus.move_left;
  assign raw_btn[BTN_RIGHT] = bus.move_right;
  assign raw_btn[BTN_PLACE] = bus.player_place_ship;

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_btn[b]),
      .pulse(btn_pulse[b])
    );
  end

  function automatic coord_t step_down(input coord_t c);
`ifdef BATTLESHIP_CURSOR_WRAP_EN
    return (c == 3'd0) ? LAST : c - 3'd1;
`else
    return (c == 3'd0) ? c : c - 3'd1;
`endif
  endfunction

  function automatic coord_t step_up(input coord_t c);
`ifdef BATTLESHIP_CURSOR_WRAP_EN
    return (c == LAST) ? 3'd0 : c + 3'd1;
`else
    return (c == LAST) ? c : c + 3'd1;
`endif
  endfunction

  assign cell_mask = CELLS'(1) << cell_idx(ci_q, cj_q, BOARD_DIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ci_q     <= '0;
      cj_q     <= '0;
      occ_q    <= '0;
      placed_q <= '0;
      target_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ci_q     <= ci_d;
      cj_q     <= cj_d;
      occ_q    <= occ_d;
      placed_q <= placed_d;
      target_q <= target_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ci_d     = ci_q;
    cj_d     = cj_q;
    occ_d    = occ_q;
    placed_d = placed_q;
    target_d = target_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_pulse[BTN_START]) begin
          target_d = (bus.amount_of_ships > MAX_T) ? MAX_T : bus.amount_of_ships;
          state_d  = (target_d == 3'd0) ? DONE : PLACE;
        end
      end
      PLACE: begin
        // One action per cycle; the if-chain order is the button priority.
        if (btn_pulse[BTN_PLACE]) begin
          if (|(occ_q & cell_mask)) begin
            reject_d = 1'b1;
          end else begin
            occ_d    = occ_q | cell_mask;
            placed_d = placed_q + 3'd1;
            if (placed_d == target_q) state_d = DONE;
          end
        end else if (btn_pulse[BTN_UP]) begin
          ci_d = step_down(ci_q);
        end else if (btn_pulse[BTN_DOWN]) begin
          ci_d = step_up(ci_q);
        end else if (btn_pulse[BTN_LEFT]) begin
          cj_d = step_down(cj_q);
        end else if (btn_pulse[BTN_RIGHT]) begin
          cj_d = step_up(cj_q);
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cursor_i       = ci_q;
  assign bus.cursor_j       = cj_q;
  assign bus.occupied       = occ_q;
  assign bus.ships_placed   = placed_q;
  assign bus.target_ships   = target_q;
  assign bus.placing_active = (state_q == PLACE);
  assign bus.placing_done   = (state_q == DONE);
  assign bus.place_reject   = reject_q;

endmodule
